// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchroniser plus stability-counter debouncer with edge pulses
//
// Purpose: conditions a raw, bouncy, asynchronous switch level into a clean
// registered level D, with one-cycle RISE/FALL pulses on each accepted change.
// A level is accepted only after STABLE_CYCLES consecutive equal synchronised
// samples; any contrary sample while timing restarts the wait.
//
// Optional feature macro: DEBOUNCE_TOGGLE_EN adds output TOGGLE, a push-on/push-off
// latch flipped on every accepted rising change.
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   D_IN   in   raw switch level (asynchronous)
//   D      out  debounced level (registered)
//   RISE   out  one-cycle pulse in the first cycle D reads 1
//   FALL   out  one-cycle pulse in the first cycle D reads 0
//   BUSY   out  a candidate level change is being timed
//   TOGGLE out  (DEBOUNCE_TOGGLE_EN only) flips on every RISE

module debounce_sync #(
    parameter int STABLE_CYCLES = 1000,  // >= 2
    parameter int CNT_W         = 10     // 2**CNT_W >= STABLE_CYCLES
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic D_IN,
    output logic D,
    output logic RISE,
    output logic FALL,
    output logic BUSY
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic TOGGLE
`endif
);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } state_t;

    // The sample that completes the stable window is the STABLE_CYCLES-th one;
    // the counter already holds STABLE_CYCLES-1 when it arrives, so it never
    // needs to represent STABLE_CYCLES itself.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync0_q, sync0_d;
    logic             sync1_q, sync1_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             d_q,     d_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
`ifdef DEBOUNCE_TOGGLE_EN
    logic             toggle_q, toggle_d;
`endif

    // Metastability filter: only sync1_q is ever looked at by the FSM.
    always_comb begin
        sync0_d = D_IN;
        sync1_d = sync0_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            S_LOW: begin
                if (sync1_q) begin
                    // This sample is the first of the window, hence cnt starts at 1.
                    state_d = S_WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!sync1_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    d_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync1_q) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOW: begin
                if (sync1_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    d_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_TOGGLE_EN
    always_comb begin
        toggle_d = toggle_q ^ rise_d;
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync0_q  <= 1'b0;
            sync1_q  <= 1'b0;
            state_q  <= S_LOW;
            cnt_q    <= '0;
            d_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
`ifdef DEBOUNCE_TOGGLE_EN
            toggle_q <= 1'b0;
`endif
        end else begin
            sync0_q  <= sync0_d;
            sync1_q  <= sync1_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
`ifdef DEBOUNCE_TOGGLE_EN
            toggle_q <= toggle_d;
`endif
        end
    end

    assign D    = d_q;
    assign RISE = rise_q;
    assign FALL = fall_q;
    assign BUSY = (state_q == S_WAIT_HIGH) || (state_q == S_WAIT_LOW);
`ifdef DEBOUNCE_TOGGLE_EN
    assign TOGGLE = toggle_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - randomized and directed self-checking bench for debounce_sync

module tb_debounce_sync;

    localparam int SC = 4;
    localparam int CW = 3;

    logic CLK;
    logic RST_N;
    logic D_IN;
    logic D, RISE, FALL, BUSY;
`ifdef DEBOUNCE_TOGGLE_EN
    logic TOGGLE;
`endif

    debounce_sync #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D_IN  (D_IN),
        .D     (D),
        .RISE  (RISE),
        .FALL  (FALL),
        .BUSY  (BUSY)
`ifdef DEBOUNCE_TOGGLE_EN
        ,
        .TOGGLE(TOGGLE)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Behavioural reference: the FSM sees D_IN as it was two edges earlier;
    // the level flips once SC consecutive samples disagree with the current level.
    bit din_q[$];
    int m_run;
    bit m_d, m_rise, m_fall, m_busy, m_tog;

    always @(posedge CLK) begin
        bit s;
        if (!RST_N) begin
            din_q.delete();
            m_run = 0; m_d = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_tog = 0;
        end else begin
            s = (din_q.size() >= 2) ? din_q[din_q.size()-2] : 1'b0;
            din_q.push_back(D_IN);
            if (din_q.size() > 4) void'(din_q.pop_front());
            m_rise = 0;
            m_fall = 0;
            m_run = (s != m_d) ? m_run + 1 : 0;
            if (m_run == SC) begin
                m_d = s;
                m_rise = s;
                m_fall = !s;
                m_tog = m_tog ^ s;
                m_run = 0;
            end
            m_busy = (m_run != 0);
        end
        #1;
        chk("model_D", D, m_d);
        chk("model_RISE", RISE, m_rise);
        chk("model_FALL", FALL, m_fall);
        chk("model_BUSY", BUSY, m_busy);
`ifdef DEBOUNCE_TOGGLE_EN
        chk("model_TOGGLE", TOGGLE, m_tog);
`endif
    end

    task automatic edge_wait();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int rises;
        int rise_edge;
        int val;
        int len;

        RST_N = 1'b0;
        D_IN  = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_D", D, 0);
        chk("reset_RISE", RISE, 0);
        chk("reset_FALL", FALL, 0);
        chk("reset_BUSY", BUSY, 0);

        // 1: held high after reset
        @(negedge CLK);
        RST_N = 1'b1;
        D_IN  = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            edge_wait();
            chk($sformatf("t1_busy_e%0d", e), BUSY, (e >= 3 && e <= 5) ? 1 : 0);
            chk($sformatf("t1_d_e%0d", e), D, (e >= 6) ? 1 : 0);
            chk($sformatf("t1_rise_e%0d", e), RISE, (e == 6) ? 1 : 0);
        end

        // 3: from D=1, held low
        @(negedge CLK);
        D_IN = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            edge_wait();
            chk($sformatf("t3_d_e%0d", e), D, (e >= 6) ? 0 : 1);
            chk($sformatf("t3_fall_e%0d", e), FALL, (e == 6) ? 1 : 0);
            chk($sformatf("t3_rise_e%0d", e), RISE, 0);
        end

        // 2: three-cycle pulse is rejected
        @(negedge CLK);
        D_IN = 1'b1;
        repeat (3) @(negedge CLK);
        D_IN = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            edge_wait();
            chk("t2_d", D, 0);
            chk("t2_rise", RISE, 0);
        end
        chk("t2_busy_end", BUSY, 0);

        // 4: bounce then settle high
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            D_IN = ~D_IN;
        end
        @(negedge CLK);
        D_IN = 1'b1;
        rises = 0;
        rise_edge = 0;
        for (int e = 1; e <= 10; e++) begin
            edge_wait();
            if (RISE) begin
                rises++;
                rise_edge = e;
            end
        end
        chk("t4_rise_count", rises, 1);
        chk("t4_rise_edge", rise_edge, 6);

        @(negedge CLK);
        D_IN = 1'b0;
        repeat (8) edge_wait();

        // 5: reset while timing a rise
        @(negedge CLK);
        D_IN = 1'b1;
        repeat (4) edge_wait();
        chk("t5_busy_before", BUSY, 1);
        RST_N = 1'b0;
        #1;
        chk("t5_rst_d", D, 0);
        chk("t5_rst_rise", RISE, 0);
        chk("t5_rst_fall", FALL, 0);
        chk("t5_rst_busy", BUSY, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            edge_wait();
            chk($sformatf("t5_rise_e%0d", e), RISE, (e == 6) ? 1 : 0);
        end
        // reset while D is high clears it at once
        chk("t5_d_high", D, 1);
        RST_N = 1'b0;
        #1;
        chk("t5b_rst_d", D, 0);
        repeat (2) @(negedge CLK);
        D_IN  = 1'b0;
        RST_N = 1'b1;

        // randomized bouncy segments
        for (int n = 0; n < 300; n++) begin
            val = $urandom_range(0, 1);
            len = $urandom_range(1, 9);
            repeat (len) begin
                @(negedge CLK);
                D_IN = val[0];
            end
        end

`ifdef DEBOUNCE_TOGGLE_EN
        // 6: push-on/push-off
        @(negedge CLK);
        RST_N = 1'b0;
        D_IN  = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        for (int p = 0; p < 3; p++) begin
            @(negedge CLK);
            D_IN = 1'b1;
            rises = 0;
            for (int e = 1; e <= 10; e++) begin
                edge_wait();
                if (RISE) begin
                    rises++;
                    chk($sformatf("t6_toggle_press%0d", p), TOGGLE, (p % 2 == 0) ? 1 : 0);
                end
            end
            chk($sformatf("t6_rises_press%0d", p), rises, 1);
            @(negedge CLK);
            D_IN = 1'b0;
            for (int e = 1; e <= 10; e++) begin
                edge_wait();
                if (FALL) chk($sformatf("t6_toggle_rel%0d", p), TOGGLE, (p % 2 == 0) ? 1 : 0);
            end
        end
`endif

        repeat (10) @(negedge CLK);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
